// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad display path.
package keypad_pkg;

  typedef enum logic [1:0] {
    SHOW_L   = 2'd0,
    BLANK_LR = 2'd1,
    SHOW_R   = 2'd2,
    BLANK_RL = 2'd3
  } mux_state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [1:0] AN_OFF    = 2'b11;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_display_mux_if.sv
// Key strobe from the keypad scanner: a 4-bit code qualified by a one-cycle valid.
interface key_if;
  logic [3:0] key_code;
  logic       key_valid;

  modport master (output key_code, output key_valid);
  modport slave  (input  key_code, input  key_valid);
endinterface

// File: rtl/seven_seg_decoder.sv
// Hex to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module seven_seg_decoder (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/key_display_mux.sv
// Two-key history driving a dual common-anode display, time-multiplexed with
// blanking slots between digits to suppress ghosting.
//
// state    | meaning
// SHOW_L   | left anode on, older key displayed
// BLANK_LR | both anodes off, left -> right transition
// SHOW_R   | right anode on, newest key displayed
// BLANK_RL | both anodes off, right -> left transition (reset state)
module key_display_mux
  import keypad_pkg::*;
#(
  parameter int REFRESH_CYCLES = 2500,
  parameter int BLANK_CYCLES   = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  key_if.slave       key,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [1:0] digits_loaded
);

  localparam int CNT_MAX = max_int(REFRESH_CYCLES, BLANK_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] REF_LAST   = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  mux_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       new_digit, old_digit;
  logic             new_ok, old_ok;
  logic [3:0]       sel_digit;
  logic             sel_ok;
  logic [6:0]       dec_seg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      new_digit     <= 4'h0;
      old_digit     <= 4'h0;
      new_ok        <= 1'b0;
      old_ok        <= 1'b0;
      digits_loaded <= 2'd0;
    end else if (key.key_valid) begin
      old_digit <= new_digit;
      old_ok    <= new_ok;
      new_digit <= key.key_code;
      new_ok    <= 1'b1;
      if (digits_loaded != 2'd2) digits_loaded <= digits_loaded + 2'd1;
    end
  end

  // One shared decoder; the state picks which history slot feeds it.
  assign sel_digit = (state == SHOW_L) ? old_digit : new_digit;
  assign sel_ok    = (state == SHOW_L) ? old_ok    : new_ok;

  seven_seg_decoder u_dec (
    .hex (sel_digit),
    .seg (dec_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BLANK_RL;
      cnt   <= '0;
      seg   <= SEG_BLANK;
      an    <= AN_OFF;
    end else begin
      case (state)
        SHOW_L: begin
          an  <= 2'b01;
          seg <= sel_ok ? dec_seg : SEG_BLANK;
          if (cnt == REF_LAST) begin
            state <= BLANK_LR;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BLANK_LR: begin
          an  <= AN_OFF;
          seg <= SEG_BLANK;
          if (cnt == BLANK_LAST) begin
            state <= SHOW_R;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHOW_R: begin
          an  <= 2'b10;
          seg <= sel_ok ? dec_seg : SEG_BLANK;
          if (cnt == REF_LAST) begin
            state <= BLANK_RL;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          an  <= AN_OFF;
          seg <= SEG_BLANK;
          if (cnt == BLANK_LAST) begin
            state <= SHOW_L;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_display_mux.sv
// Scoreboard bench: a slot-position/key-list model predicts every output edge.
module tb_key_display_mux;
  import keypad_pkg::*;

  localparam int R   = 8;
  localparam int B   = 2;
  localparam int PER = 2 * (R + B);

  typedef struct {
    logic [6:0] seg;
    logic [1:0] an;
    logic [1:0] dl;
    int         edge_no;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg;
  logic [1:0] an;
  logic [1:0] dl;

  key_if kif ();

  key_display_mux #(.REFRESH_CYCLES(R), .BLANK_CYCLES(B)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key           (kif),
    .seg           (seg),
    .an            (an),
    .digits_loaded (dl)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  exp_t       exp_q [$];
  logic [3:0] hist [$];
  int         k = 0;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, want);
    end
  endtask

  always @(negedge rst_n) begin
    k = 0;
    hist.delete();
    exp_q.delete();
  end

  // Reference model: output after edge k reflects slot position (k-1) mod period
  // and the key list as it stood before that edge.
  always @(posedge clk) begin
    exp_t e;
    int   p;
    if (rst_n) begin
      k++;
      p = (k - 1) % PER;
      e.edge_no = k;
      if (p < B || (p >= B + R && p < 2 * B + R)) begin
        e.an  = 2'b11;
        e.seg = 7'b1111111;
      end else if (p < B + R) begin
        e.an  = 2'b01;
        e.seg = (hist.size() == 2) ? seg_tab[hist[0]] : 7'b1111111;
      end else begin
        e.an  = 2'b10;
        e.seg = (hist.size() >= 1) ? seg_tab[hist[hist.size()-1]] : 7'b1111111;
      end
      if (kif.key_valid) begin
        hist.push_back(kif.key_code);
        if (hist.size() > 2) void'(hist.pop_front());
      end
      e.dl = 2'(hist.size());
      exp_q.push_back(e);
    end
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("an", int'(an), int'(e.an));
      check("seg", int'(seg), int'(e.seg));
      check("digits_loaded", int'(dl), int'(e.dl));
    end
  end

  task automatic key(input logic [3:0] c);
    @(negedge clk);
    kif.key_valid = 1'b1;
    kif.key_code  = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      kif.key_valid = 1'b0;
    end
  endtask

  // Stops at a negedge where the next edge falls at slot position lo..hi.
  task automatic wait_phase(input int lo, input int hi);
    bit found = 1'b0;
    for (int i = 0; i < PER + 2 && !found; i++) begin
      @(negedge clk);
      kif.key_valid = 1'b0;
      if ((k % PER) >= lo && (k % PER) <= hi) found = 1'b1;
    end
    check("phase_reached", int'(found), 1);
  endtask

  task automatic do_reset();
    kif.key_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_seg", int'(seg), int'(SEG_BLANK));
    check("rst_an", int'(an), int'(AN_OFF));
    check("rst_dl", int'(dl), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    kif.key_valid = 1'b0;
    kif.key_code  = 4'h0;
    repeat (3) @(negedge clk);
    do_reset();
    idle(25);
    key(4'h1);
    idle(25);
    key(4'hA);
    idle(3);
    key(4'hF);
    idle(25);
    key(4'h0);
    idle(25);
    wait_phase(2 * B + R + 1, PER - 3);
    key(4'h3);
    key(4'h7);
    idle(25);
    wait_phase(B + 1, B + R - 2);
    do_reset();
    idle(25);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      kif.key_valid = ($urandom_range(0, 4) == 0);
      kif.key_code  = 4'($urandom);
    end
    idle(5);
    @(negedge clk);
    do_reset();
    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_display_mux.md
# key_display_mux

Consumer of the keypad scanner's `key_code`/`key_valid` pair. It keeps a two-entry history of accepted keys and drives a dual common-anode seven-segment display by time-multiplexing. The older key goes on the left digit and the newest on the right. Between digits it inserts a blanking interval to suppress ghosting. It sits between the scanner and the board-level display pins.

## Interface
- `REFRESH_CYCLES`, default 2500: clock cycles each digit is lit per multiplex slot; legal range ≥ 2.
- `BLANK_CYCLES`, default 50: clock cycles with both anodes off between slots; legal range ≥ 1.
- `clk` in 1: system clock.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `key_code` in 4: hex value of the accepted key; sampled only when `key_valid`=1.
- `key_valid` in 1: single-cycle strobe marking a new debounced key.
- `seg` out 7: segment drive {g,f,e,d,c,b,a}, active-low, registered.
- `an` out 2: anode enables {left,right}, active-low, registered.
- `digits_loaded` out 2: number of keys captured since reset, saturating at 2. Value 0, 1 or 2.

## Operation
- **History registers.** `new_digit`/`new_ok` hold the newest key; `old_digit`/`old_ok` hold the key before it.
- **Key capture.** On a clk edge with `key_valid`=1:
  - `old_digit` ← `new_digit`, `old_ok` ← `new_ok`.
  - `new_digit` ← `key_code`, `new_ok` ← 1.
  - `digits_loaded` ← min(`digits_loaded`+1, 2).
- **Back-to-back strobes.** Consecutive `key_valid` cycles each shift; no strobe is dropped.
- **Empty digit.** A digit whose `_ok` flag is 0 displays blank: `seg`=7'b1111111.
- **Multiplex FSM states:** SHOW_L, BLANK_LR, SHOW_R, BLANK_RL. The slot counter resets to 0 on every state entry.
  - SHOW_L: `an`=2'b01, `seg`=decode(`old_digit`). After REFRESH_CYCLES cycles in state → BLANK_LR.
  - BLANK_LR: `an`=2'b11, `seg`=7'b1111111. After BLANK_CYCLES cycles → SHOW_R.
  - SHOW_R: `an`=2'b10, `seg`=decode(`new_digit`). After REFRESH_CYCLES cycles → BLANK_RL.
  - BLANK_RL: `an`=2'b11, `seg`=7'b1111111. After BLANK_CYCLES cycles → SHOW_L.
- **Anode overlap.** `an`=2'b00 is never driven.
- **Decode, active-low {g..a}:**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- **Slot counter.** Width is $clog2(max(REFRESH_CYCLES, BLANK_CYCLES)). It wraps only via state exit, never by overflow.

## Timing
- **Reset (asserted or mid-operation):** immediately and asynchronously:
  - `seg`=7'b1111111, `an`=2'b11, `digits_loaded`=0
  - both `_ok`=0, both digits=0
  - FSM=BLANK_RL, counter=0
- **After reset release:** first SHOW_L begins BLANK_CYCLES cycles later. Its digit is blank until two keys have been captured.
- **Output latency.** `seg`/`an` are registered and reflect state/history one cycle after the internal change.
- **Key update latency.** `key_valid` at edge N updates history at edge N. The change is visible on `seg` at edge N+1 if the affected digit is currently lit.
- **Key during a blank state.** The history updates normally. The new value appears at the start of the next SHOW slot, with no glitch on `seg`.
- **Key during a SHOW slot.** The history updates and `seg` changes mid-slot. `an` is unaffected and the slot length is unchanged.
- **Slot lengths.** Each SHOW slot is exactly REFRESH_CYCLES cycles and each BLANK slot exactly BLANK_CYCLES cycles. Full period = 2·(REFRESH_CYCLES+BLANK_CYCLES).

## Structure
- **Package `keypad_pkg`:**
  - `mux_state_t` enum (SHOW_L, BLANK_LR, SHOW_R, BLANK_RL)
  - `SEG_BLANK` = 7'b1111111
  - `AN_OFF` = 2'b11
- **Sub-module `seven_seg_decoder`:** purely combinational, 4-bit hex in, 7-bit active-low {g..a} out, table as above. It is instantiated once, fed from a mux selecting `old_digit` or `new_digit` by state.
- **Top.** History registers, FSM, slot counter and output registers live in `key_display_mux`.

## Test plan
Parameters for all scenarios: REFRESH_CYCLES=8, BLANK_CYCLES=2.
- **Reset and startup:** hold `rst_n`=0 → `seg`=1111111, `an`=11, `digits_loaded`=0. Release → `an` sequence is 11×2, 01×8, 11×2, 10×8, repeating, with `seg`=1111111 throughout.
- **Single key:** one `key_valid` strobe with `key_code`=4'h1 → `digits_loaded`=1. SHOW_R shows `seg`=1111001; SHOW_L stays 1111111.
- **Two keys:** strobes 4'hA then 4'hF, 3 cycles apart → SHOW_L `seg`=0001000, SHOW_R `seg`=0001110, `digits_loaded`=2.
- **Third key:** a further strobe 4'h0 → left shows F (0001110), right shows 0 (1000000), `digits_loaded` stays 2.
- **Back-to-back and mid-slot:** strobes 4'h3 and 4'h7 on consecutive cycles during SHOW_R → `seg` shows 0110000 then 1111000 one cycle after each strobe. The slot still ends after 8 cycles, and the next SHOW_L shows 3.
- **Reset mid-slot:** assert `rst_n` during SHOW_L with two keys loaded → outputs blank and `an`=11 within the same cycle. After release both digits stay blank until new strobes arrive.
